// File: rtl/rf_pkg.sv
// rf_pkg: shared sizes and constants for the 8x16 register file
package rf_pkg;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NREG = 8;
    localparam logic [AW-1:0] ZERO_REG = 3'd0;
endpackage

// File: rtl/rf_reg16.sv
// rf_reg16: 16-bit register with async active-low clear and load enable
// Ports: clk, rst (active-low async clear), en (load), d (next value), q (stored value)
module rf_reg16
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 8x16 register file with write-through bypass, hardwired-zero R0 and pending-write scoreboard
// Ports: clk, rst (active-low async); ra1/ra2 -> rd1/rd2 combinational reads;
// we/wa/wd write port; iss_v/iss_rd mark a multi-cycle op outstanding;
// haz1/haz2 flag reads of outstanding registers; pend exposes the scoreboard
module reg_file_8x16
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [DW-1:0]   rd1,
    output logic [DW-1:0]   rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [DW-1:0]   wd,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    output logic            haz1,
    output logic            haz2,
    output logic [NREG-1:0] pend
);
    logic [NREG-1:0][DW-1:0] regs;
    logic [NREG-1:0]         set_v, clr_v;
    logic                    wr, byp1, byp2;

    assign regs[0] = '0;
    for (genvar k = 1; k < NREG; k++) begin : g_reg
        rf_reg16 u_reg (
            .clk (clk),
            .rst (rst),
            .en  (we && wa == AW'(k)),
            .d   (wd),
            .q   (regs[k])
        );
    end

    assign wr   = we && wa != ZERO_REG;
    assign byp1 = wr && wa == ra1;
    assign byp2 = wr && wa == ra2;
    // outputs are forced quiet while reset is held, even if a write is being driven
    assign rd1  = !rst ? '0 : byp1 ? wd : regs[ra1];
    assign rd2  = !rst ? '0 : byp2 ? wd : regs[ra2];
    assign haz1 = rst && pend[ra1] && !byp1;
    assign haz2 = rst && pend[ra2] && !byp2;

    assign set_v = (iss_v && iss_rd != ZERO_REG) ? NREG'(1) << iss_rd : '0;
    assign clr_v = wr ? NREG'(1) << wa : '0;

    // clear is applied first so a same-register issue keeps the bit set
    always_ff @(posedge clk or negedge rst)
        if (!rst) pend <= '0;
        else pend <= (pend & ~clr_v) | set_v;
endmodule

// File: tb/tb_reg_file_8x16.sv
// tb_reg_file_8x16: directed plus randomized self-checking bench for reg_file_8x16
module tb_reg_file_8x16;
    logic        clk = 0;
    logic        rst = 0;
    logic [2:0]  ra1 = 0, ra2 = 0, wa = 0, iss_rd = 0;
    logic [15:0] wd = 0;
    logic        we = 0, iss_v = 0;
    logic [15:0] rd1, rd2;
    logic        haz1, haz2;
    logic [7:0]  pend;

    int n_err = 0;
    int n_chk = 0;
    bit checking = 0;

    logic [15:0] m [8] = '{default: 16'h0};
    logic [7:0]  pm = 8'h00;

    reg_file_8x16 dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_rd(iss_rd),
        .haz1(haz1), .haz2(haz2), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: architectural register contents and outstanding-write set
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) m[i] = 16'h0;
            pm = 8'h00;
        end else begin
            if (we && wa != 0) begin
                m[wa] = wd;
                pm[wa] = 1'b0;
            end
            if (iss_v && iss_rd != 0) pm[iss_rd] = 1'b1;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        if (!rst || a == 0) return 16'h0;
        if (we && wa == a) return wd;
        return m[a];
    endfunction

    function automatic logic exp_haz(input logic [2:0] a);
        return rst && a != 0 && pm[a] && !(we && wa == a);
    endfunction

    always @(negedge clk) if (checking) begin
        chk("cmp_rd1", 32'(rd1), 32'(exp_rd(ra1)));
        chk("cmp_rd2", 32'(rd2), 32'(exp_rd(ra2)));
        chk("cmp_haz1", 32'(haz1), 32'(exp_haz(ra1)));
        chk("cmp_haz2", 32'(haz2), 32'(exp_haz(ra2)));
        chk("cmp_pend", 32'(pend), 32'(rst ? pm : 8'h00));
    end

    task automatic drive(input logic w, input logic [2:0] a, input logic [15:0] d,
                         input logic [2:0] r1, input logic [2:0] r2,
                         input logic iv, input logic [2:0] ir);
        @(posedge clk);
        #1;
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; iss_v = iv; iss_rd = ir;
        #1;
    endtask

    initial begin
        @(posedge clk); #2;
        chk("reset_rd1", 32'(rd1), 32'h0);
        chk("reset_pend", 32'(pend), 32'h0);
        chk("reset_haz", 32'({haz1, haz2}), 32'h0);
        rst = 1;
        checking = 1;

        drive(1, 3, 16'hBEEF, 3, 0, 0, 0);
        drive(0, 0, 0, 3, 0, 1, 5);
        chk("preload_r3", 32'(rd1), 32'hBEEF);
        rst = 0;
        #1;
        chk("async_rst_rd1", 32'(rd1), 32'h0);
        chk("async_rst_pend", 32'(pend), 32'h0);
        rst = 1;
        #1;
        chk("after_rst_r3", 32'(rd1), 32'h0);

        drive(1, 5, 16'h1234, 0, 0, 0, 0);
        drive(0, 0, 0, 5, 5, 0, 0);
        chk("wr_rd1", 32'(rd1), 32'h1234);
        chk("wr_rd2", 32'(rd2), 32'h1234);

        drive(1, 0, 16'hFFFF, 0, 0, 0, 0);
        chk("r0_bypass", 32'(rd1), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_read", 32'(rd1), 32'h0);

        drive(1, 2, 16'h0007, 0, 0, 0, 0);
        drive(1, 2, 16'h00A5, 2, 0, 0, 0);
        chk("bypass_rd1", 32'(rd1), 32'h00A5);
        drive(0, 0, 0, 2, 0, 0, 0);
        chk("bypass_after", 32'(rd1), 32'h00A5);

        drive(0, 0, 0, 0, 4, 1, 4);
        drive(0, 0, 0, 0, 4, 0, 0);
        chk("sb_haz2", 32'(haz2), 32'h1);
        chk("sb_pend", 32'(pend), 32'h10);
        drive(1, 4, 16'h0F0F, 0, 4, 0, 0);
        chk("sb_wr_haz2", 32'(haz2), 32'h0);
        chk("sb_wr_rd2", 32'(rd2), 32'h0F0F);
        drive(0, 0, 0, 0, 4, 0, 0);
        chk("sb_clear", 32'(pend), 32'h00);

        drive(0, 0, 0, 0, 0, 1, 6);
        drive(1, 6, 16'h0001, 6, 0, 1, 6);
        drive(0, 0, 0, 6, 0, 0, 0);
        chk("same_pend", 32'(pend), 32'h40);
        chk("same_r6", 32'(rd1), 32'h0001);
        chk("same_haz1", 32'(haz1), 32'h1);
        drive(1, 6, 16'h0002, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("diff_pend", 32'(pend), 32'h02);

        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("iss0_pend", 32'(pend), 32'h02);
        chk("iss0_haz1", 32'(haz1), 32'h0);
        chk("iss0_rd1", 32'(rd1), 32'h0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom),
                  1'($urandom_range(0, 2) == 0), 3'($urandom));
            if ($urandom_range(0, 63) == 0) begin
                rst = 0;
                #1;
                chk("rnd_rst_rd1", 32'(rd1), 32'h0);
                chk("rnd_rst_haz", 32'({haz1, haz2}), 32'h0);
                rst = 1;
            end
        end

        @(posedge clk);
        checking = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_8x16.md
Name: reg_file_8x16

Overview:
- 8-entry × 16-bit general-purpose register file for the 16-bit single-cycle RISC core.
- Built from per-word 16-bit enabled registers.
- Consumes write-back data from the write-back mux and feeds operands to the ALU/decode stage.
- Adds write-through bypass, a hardwired-zero R0, and a pending-write scoreboard so that multi-cycle producers (memory load, future multiplier) stall dependent readers.

Parameters:
- DW, 16, data width of each register
- NREG, 8, number of registers
- AW, 3, address width (log2 NREG)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- ra1  input  AW  read address, port A
- ra2  input  AW  read address, port B
- rd1  output  DW  read data, port A
- rd2  output  DW  read data, port B
- we  input  1  write enable
- wa  input  AW  write address
- wd  input  DW  write data
- iss_v  input  1  issue of a multi-cycle op whose result targets iss_rd
- iss_rd  input  AW  destination of the issued multi-cycle op
- haz1  output  1  port A reads a register with an outstanding write
- haz2  output  1  port B reads a register with an outstanding write
- pend  output  NREG  scoreboard vector, for debug/verification

Behaviour:
- Reset:
  - rst low clears all registers and pend to 0 immediately, independent of clk.
  - While rst is low: rd1=rd2=0, haz1=haz2=0.
  - Reset mid-operation discards any in-flight write and all pending bits.
- Storage:
  - Word k (1..NREG-1) loads wd on the rising clk edge when we=1 and wa=k.
  - Otherwise word k holds its value.
- R0:
  - Always reads 0.
  - Writes to address 0 are dropped.
  - Issues to iss_rd=0 are dropped, so pend[0] is always 0.
- Read:
  - Combinational, 0-cycle latency: rdN = reg[raN].
  - Bypass: if we=1, wa=raN and raN≠0, then rdN = wd in the same cycle (write-through).
- Write visibility: the stored value appears on the cycle after the write edge; the bypass covers the write cycle itself.
- Scoreboard:
  - On a clk edge, iss_v=1 with iss_rd≠0 sets pend[iss_rd].
  - On a clk edge, we=1 with wa≠0 clears pend[wa].
  - Same edge, iss_rd = wa ≠ 0: set wins. The old result retires and the new op is outstanding.
  - Same edge, different addresses: both actions apply.
- Hazard:
  - hazN = pend[raN] & ~(we & wa==raN) & (raN≠0).
  - A write in the current cycle resolves the hazard through the bypass.
- Writes to a non-pending register are legal: plain single-cycle ALU write-back.
- Width: no arithmetic; all addresses are unsigned and must be in range 0..NREG-1.

Decomposition:
- Package rf_pkg holds: DW, AW, NREG, ZERO_REG = 3'd0.
- One sub-module rf_reg16: 16-bit register with async active-low clear and load enable, instantiated NREG-1 times (R0 has none).
- Address decode, bypass muxes and scoreboard stay in the top module.

Test Plan:
- Reset:
  - Stimulus: preload r3=16'hBEEF, then pulse rst low mid-cycle.
  - Required: rd1 with ra1=3 becomes 0 immediately, without waiting for a clk edge; pend=8'h00.
- Write/read:
  - Stimulus: we=1, wa=5, wd=16'h1234 for one edge; then ra1=5, ra2=5.
  - Required: rd1=rd2=16'h1234.
  - Stimulus: write wa=0, wd=16'hFFFF.
  - Required: ra1=0 still returns 0.
- Bypass:
  - Stimulus: r2 holds 16'h0007; in one cycle drive we=1, wa=2, wd=16'h00A5, ra1=2.
  - Required: rd1=16'h00A5 before the edge, and still 16'h00A5 after it.
- Scoreboard:
  - Stimulus: iss_v=1, iss_rd=4 for one edge; then ra2=4.
  - Required: haz2=1 and pend=8'h10 until the write edge.
  - Stimulus: we=1, wa=4, wd=16'h0F0F.
  - Required: haz2=0 in that cycle with rd2=16'h0F0F; pend=8'h00 after the edge.
- Simultaneous set/clear:
  - Stimulus: pend[6]=1; on one edge drive iss_v=1, iss_rd=6, we=1, wa=6, wd=16'h0001.
  - Required: pend[6] remains 1; r6=16'h0001.
  - Stimulus: same edge with iss_rd=1, wa=6.
  - Required: pend=8'h02.
- Issue to R0:
  - Stimulus: iss_v=1, iss_rd=0; ra1=0.
  - Required: pend unchanged, haz1=0, rd1=0.
